// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the five-stage pipeline sequencer.
package pipe_ctrl_pkg;

  localparam int STALL_W  = 6;
  localparam int MC_CNT_W = 5;
  localparam int PC_W     = 32;

  // Per-stage hold vectors. Bit 0 is pc_reg, bit 4 is MEM/WB, and bit 5 (WB) is reserved.
  localparam logic [STALL_W-1:0] StallNone = 6'b000000;
  localparam logic [STALL_W-1:0] StallIF   = 6'b000011;
  localparam logic [STALL_W-1:0] StallID   = 6'b000111;
  localparam logic [STALL_W-1:0] StallEX   = 6'b001111;

  typedef enum logic [1:0] {
    CtrlIdle  = 2'd0,
    CtrlMc    = 2'd1,
    CtrlFlush = 2'd2
  } ctrl_state_e;

  // Operations of zero or one cycle complete in the start cycle and never stall.
  function automatic logic mc_is_long(input logic [MC_CNT_W-1:0] n);
    return (n >= 5'd2);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the pipeline stages and the sequencer.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic                stallreq_if_i;
  logic                stallreq_id_i;
  logic                mc_start_i;
  logic [MC_CNT_W-1:0] mc_cycles_i;
  logic                flush_req_i;
  logic [PC_W-1:0]     flush_pc_i;
  logic [STALL_W-1:0]  stall_o;
  logic                flush_o;
  logic [PC_W-1:0]     new_pc_o;
  logic                mc_busy_o;
  logic                mc_done_o;

  // Pipeline side: raises requests and consumes the control outputs.
  modport master (
    output stallreq_if_i, stallreq_id_i, mc_start_i, mc_cycles_i, flush_req_i, flush_pc_i,
    input  stall_o, flush_o, new_pc_o, mc_busy_o, mc_done_o
  );

  // Sequencer side.
  modport slave (
    input  stallreq_if_i, stallreq_id_i, mc_start_i, mc_cycles_i, flush_req_i, flush_pc_i,
    output stall_o, flush_o, new_pc_o, mc_busy_o, mc_done_o
  );

endinterface

// File: rtl/pipe_ctrl_mc_cnt.sv
// Loadable down-counter that tracks the remaining EX occupancy of a multi-cycle op.
module pipe_ctrl_mc_cnt
  import pipe_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic [MC_CNT_W-1:0] load_val_i,
  input  logic                clear_i,
  output logic [MC_CNT_W-1:0] cnt_o,
  output logic                last_o
);

  logic [MC_CNT_W-1:0] cnt_d;
  logic [MC_CNT_W-1:0] cnt_q;

  // Next count: an abort clear beats a load, otherwise count down to zero and hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = {MC_CNT_W{1'b0}};
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != {MC_CNT_W{1'b0}}) begin
      cnt_d = cnt_q - 5'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= {MC_CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == 5'd1);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stall requests, times multi-cycle EX ops, issues redirects.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  ctrl_state_e         state_d;
  ctrl_state_e         state_q;
  logic                flush_d;
  logic                flush_q;
  logic [PC_W-1:0]     new_pc_d;
  logic [PC_W-1:0]     new_pc_q;
  logic                cnt_load_s;
  logic [MC_CNT_W-1:0] cnt_s;
  logic                cnt_last_s;
  logic                mc_long_s;
  logic                mc_done_s;
  logic [STALL_W-1:0]  stall_s;

  assign mc_long_s = mc_is_long(bus.mc_cycles_i);

  pipe_ctrl_mc_cnt u_mc_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load_s),
    .load_val_i (bus.mc_cycles_i - 5'd1),
    .clear_i    (bus.flush_req_i),
    .cnt_o      (cnt_s),
    .last_o     (cnt_last_s)
  );

  // Next-state logic. A redirect always wins: it aborts a running op and ignores a start.
  always_comb begin
    state_d    = state_q;
    cnt_load_s = 1'b0;
    mc_done_s  = 1'b0;
    flush_d    = bus.flush_req_i;
    if (bus.flush_req_i) begin
      new_pc_d = bus.flush_pc_i;
    end else begin
      new_pc_d = new_pc_q;
    end
    case (state_q)
      CtrlIdle: begin
        if (bus.flush_req_i) begin
          state_d = CtrlFlush;
        end else if (bus.mc_start_i && mc_long_s) begin
          cnt_load_s = 1'b1;
          state_d    = CtrlMc;
        end else if (bus.mc_start_i) begin
          mc_done_s = 1'b1;
          state_d   = CtrlIdle;
        end else begin
          state_d = CtrlIdle;
        end
      end
      CtrlMc: begin
        if (bus.flush_req_i) begin
          state_d = CtrlFlush;
        end else if (cnt_last_s) begin
          mc_done_s = 1'b1;
          state_d   = CtrlIdle;
        end else begin
          state_d = CtrlMc;
        end
      end
      CtrlFlush: begin
        if (bus.flush_req_i) begin
          state_d = CtrlFlush;
        end else begin
          state_d = CtrlIdle;
        end
      end
      default: begin
        state_d = CtrlIdle;
      end
    endcase
  end

  // Stall priority: redirect cycle, then EX occupancy, then load-use, then fetch.
  always_comb begin
    stall_s = StallNone;
    if (state_q == CtrlFlush) begin
      stall_s = StallNone;
    end else if (((state_q == CtrlMc) && (cnt_s > 5'd1)) ||
                 ((state_q == CtrlIdle) && bus.mc_start_i && mc_long_s)) begin
      stall_s = StallEX;
    end else if (bus.stallreq_id_i) begin
      stall_s = StallID;
    end else if (bus.stallreq_if_i) begin
      stall_s = StallIF;
    end else begin
      stall_s = StallNone;
    end
  end

  // State and redirect registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= CtrlIdle;
      flush_q  <= 1'b0;
      new_pc_q <= {PC_W{1'b0}};
    end else begin
      state_q  <= state_d;
      flush_q  <= flush_d;
      new_pc_q <= new_pc_d;
    end
  end

  // Combinational outputs are forced quiet while reset is held.
  assign bus.stall_o   = rst ? stall_s : StallNone;
  assign bus.mc_busy_o = rst & (state_q == CtrlMc);
  assign bus.mc_done_o = rst & mc_done_s;
  assign bus.flush_o   = flush_q;
  assign bus.new_pc_o  = new_pc_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a cycle model queues expectations, negedge samples compare.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        busy;
    logic        done;
  } exp_t;

  logic clk;
  logic rst;
  pipe_ctrl_if bus ();

  pipe_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  // Reference model state
  int          m_left  = 0;   // remaining EX occupancy cycles of a running op, 0 when none
  bit          m_flush = 1'b0;
  logic [31:0] m_pc    = 32'h0;
  bit          m_valid = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starting a multi-cycle op while one is running is a protocol violation.
  assert property (@(posedge clk) disable iff (!rst) !(bus.mc_start_i && bus.mc_busy_o))
    else $error("protocol: mc_start_i asserted during multi-cycle op");

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model_expect();
    exp_t e;
    bit   long_op;
    long_op = (bus.mc_cycles_i >= 5'd2);
    e.flush = m_flush;
    e.pc    = m_pc;
    if (!rst) begin
      e.stall = 6'b000000;
      e.busy  = 1'b0;
      e.done  = 1'b0;
    end else begin
      if (m_flush)
        e.stall = 6'b000000;
      else if (m_left > 1 || (m_left == 0 && bus.mc_start_i && long_op))
        e.stall = 6'b001111;
      else if (bus.stallreq_id_i)
        e.stall = 6'b000111;
      else if (bus.stallreq_if_i)
        e.stall = 6'b000011;
      else
        e.stall = 6'b000000;
      e.busy = (m_left > 0);
      e.done = !bus.flush_req_i &&
               ((m_left == 1) || (m_left == 0 && !m_flush && bus.mc_start_i && !long_op));
    end
    return e;
  endfunction

  task automatic model_step();
    if (!rst) begin
      m_left  = 0;
      m_flush = 1'b0;
      m_pc    = 32'h0;
      m_valid = 1'b1;
    end else if (bus.flush_req_i) begin
      m_flush = 1'b1;
      m_pc    = bus.flush_pc_i;
      m_left  = 0;
    end else begin
      if (m_left > 0)
        m_left = m_left - 1;
      else if (!m_flush && bus.mc_start_i && bus.mc_cycles_i >= 5'd2)
        m_left = int'(bus.mc_cycles_i) - 1;
      m_flush = 1'b0;
    end
  endtask

  task automatic drive(input bit r, input bit req_if, input bit req_id, input bit start,
                       input logic [4:0] n, input bit fr, input logic [31:0] pc);
    exp_t e;
    @(posedge clk);
    #1;
    rst               = r;
    bus.stallreq_if_i = req_if;
    bus.stallreq_id_i = req_id;
    bus.mc_start_i    = start;
    bus.mc_cycles_i   = n;
    bus.flush_req_i   = fr;
    bus.flush_pc_i    = pc;
    exp_q.push_back(model_expect());
    @(negedge clk);
    e = exp_q.pop_front();
    check_eq("stall_o", {26'h0, bus.stall_o}, {26'h0, e.stall});
    check_eq("mc_busy_o", {31'h0, bus.mc_busy_o}, {31'h0, e.busy});
    check_eq("mc_done_o", {31'h0, bus.mc_done_o}, {31'h0, e.done});
    if (m_valid) begin
      check_eq("flush_o", {31'h0, bus.flush_o}, {31'h0, e.flush});
      check_eq("new_pc_o", bus.new_pc_o, e.pc);
    end
    model_step();
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst               = 1'b0;
    bus.stallreq_if_i = 1'b1;
    bus.stallreq_id_i = 1'b1;
    bus.mc_start_i    = 1'b1;
    bus.mc_cycles_i   = 5'd4;
    bus.flush_req_i   = 1'b1;
    bus.flush_pc_i    = 32'hdead_beef;

    // Reset held two cycles with every request active
    drive(1'b0, 1'b1, 1'b1, 1'b1, 5'd4, 1'b1, 32'hdead_beef);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 5'd4, 1'b1, 32'hdead_beef);
    idle(2);

    // Priority ladder; the last step starts an N=4 op
    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 32'h0);
    idle(5);

    // Multi-cycle N=4 with stall requests during MC (masked), then N=1 and N=0
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0);
    idle(4);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 32'h0);
    idle(1);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 32'h0);
    idle(1);

    // Single redirect
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h0000_0040);
    idle(2);

    // Redirect aborting an N=8 op at t2
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 32'h0);
    idle(1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h0000_0100);
    idle(9);

    // Back-to-back redirects
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h0000_0040);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h0000_0080);
    idle(2);

    // Randomised traffic; starts are only issued when no op is running
    for (int i = 0; i < 400; i++) begin
      bit          s;
      logic [4:0]  nn;
      s  = (m_left == 0) && ($urandom_range(0, 3) == 0);
      nn = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
      drive(($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            s, nn, ($urandom_range(0, 9) == 0), $urandom);
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
